// File: rtl/fusion_pkg.sv
// Shared definitions for the fusion product path: precision mode encodings,
// accumulator FSM states and the default accumulator width.
package fusion_pkg;

  localparam int unsigned ACC_W_DEFAULT = 24;

  localparam logic [1:0] MODE_8B   = 2'b00;
  localparam logic [1:0] MODE_4B   = 2'b01;
  localparam logic [1:0] MODE_2B   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/fusion_lane_extract.sv
// Splits a fusion_unit product word into four lanes according to the precision
// mode, sign- or zero-extending each lane to the accumulator width.
module fusion_lane_extract
  import fusion_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic [15:0]            product,
  input  logic [1:0]             mode,
  input  logic                   sgn,
  output logic [3:0][ACC_W-1:0]  lanes
);

  always_comb begin
    lanes = '0;
    case (mode)
      MODE_4B: begin
        lanes[0] = {{(ACC_W-8){sgn & product[7]}},  product[7:0]};
        lanes[1] = {{(ACC_W-8){sgn & product[15]}}, product[15:8]};
      end
      MODE_2B: begin
        for (int unsigned k = 0; k < 4; k++) begin
          lanes[k] = {{(ACC_W-4){sgn & product[4*k+3]}}, product[4*k +: 4]};
        end
      end
      // Reserved mode extracts as 8x8; the error flag is raised by the accumulator.
      default: begin
        lanes[0] = {{(ACC_W-16){sgn & product[15]}}, product};
      end
    endcase
  end

endmodule

// File: rtl/fusion_accumulator.sv
// Per-lane dot-product accumulator downstream of fusion_unit: accumulates a
// burst of product beats and presents the four lanes on a valid/ready output.
module fusion_accumulator
  import fusion_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEFAULT,
  parameter int unsigned PROD_W = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PROD_W-1:0]    product,
  input  logic [1:0]           mode,
  input  logic                 sx,
  input  logic                 sy,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*ACC_W-1:0]   acc_out,
  output logic [1:0]           out_mode,
  output logic [15:0]          beat_cnt,
  output logic                 mode_err
);

  state_t                 state;
  state_t                 state_next;
  logic                   accept;
  logic [1:0]             mode_q;
  logic                   sgn_q;
  logic [1:0]             ext_mode;
  logic                   ext_sgn;
  logic [3:0][ACC_W-1:0]  lanes;
  logic [3:0][ACC_W-1:0]  acc;

  assign accept = in_valid & in_ready;

  // First beat of a burst extracts with its own mode/sign; later beats use the latched ones.
  assign ext_mode = (state == ST_IDLE) ? mode : mode_q;
  assign ext_sgn  = (state == ST_IDLE) ? (sx | sy) : sgn_q;

  fusion_lane_extract #(
    .ACC_W (ACC_W)
  ) u_extract (
    .product (product),
    .mode    (ext_mode),
    .sgn     (ext_sgn),
    .lanes   (lanes)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          state_next = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_valid && out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != ST_HOLD);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc       <= '0;
      mode_q    <= MODE_8B;
      sgn_q     <= 1'b0;
      beat_cnt  <= '0;
      mode_err  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_next == ST_HOLD);
      if (accept) begin
        if (state == ST_IDLE) begin
          acc      <= lanes;
          mode_q   <= mode;
          sgn_q    <= sx | sy;
          beat_cnt <= 16'd1;
          mode_err <= (mode == MODE_RSVD);
        end else begin
          for (int unsigned k = 0; k < 4; k++) begin
            acc[k] <= acc[k] + lanes[k];
          end
          if (beat_cnt != '1) begin
            beat_cnt <= beat_cnt + 16'd1;
          end
          if (mode != mode_q) begin
            mode_err <= 1'b1;
          end
        end
      end
    end
  end

  assign acc_out  = acc;
  assign out_mode = mode_q;

endmodule

// File: tb/tb_fusion_accumulator.sv
// Directed self-checking bench for fusion_accumulator with hand-computed expectations.
module tb_fusion_accumulator;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] product;
  logic [1:0]  mode;
  logic        sx;
  logic        sy;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] acc_out;
  logic [1:0]  out_mode;
  logic [15:0] beat_cnt;
  logic        mode_err;

  int checks;
  int failures;

  fusion_accumulator #(
    .ACC_W  (24),
    .PROD_W (16)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .mode      (mode),
    .sx        (sx),
    .sy        (sy),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .out_mode  (out_mode),
    .beat_cnt  (beat_cnt),
    .mode_err  (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one beat for a single cycle; in_ready is known high when called.
  task automatic send(input logic [15:0] p, input logic [1:0] m,
                      input logic s_x, input logic s_y, input logic last);
    product  = p;
    mode     = m;
    sx       = s_x;
    sy       = s_y;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [95:0] held;

  initial begin
    checks    = 0;
    failures  = 0;
    nrst      = 1'b0;
    in_valid  = 1'b0;
    product   = '0;
    mode      = 2'b00;
    sx        = 1'b0;
    sy        = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_acc",      acc_out,   96'h0);
    check("rst_in_ready", in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_beat_cnt", beat_cnt,  0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Reset asserted mid-burst
    send(16'h1234, 2'b00, 0, 0, 0);
    check("mid_beat_cnt", beat_cnt, 1);
    check("mid_in_ready", in_ready, 1);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_acc",      acc_out,  96'h0);
    check("mid_rst_beat_cnt", beat_cnt, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    send(16'h0001, 2'b00, 0, 0, 1);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_acc",   acc_out,   {24'h0, 24'h0, 24'h0, 24'h000001});
    handshake();

    // Mode 00 signed: 96 + (-169) = -73
    send(16'h0060, 2'b00, 0, 1, 0);
    send(16'hFF57, 2'b00, 0, 1, 1);
    check("m00s_valid",    out_valid, 1);
    check("m00s_acc",      acc_out,   {24'h0, 24'h0, 24'h0, 24'hFFFFB7});
    check("m00s_beat_cnt", beat_cnt,  2);
    check("m00s_in_ready", in_ready,  0);
    handshake();
    check("m00s_idle_valid", out_valid, 0);

    // Mode 10 unsigned: nibbles 1,2,4,9 summed three times
    send(16'h9421, 2'b10, 0, 0, 0);
    send(16'h9421, 2'b10, 0, 0, 0);
    send(16'h9421, 2'b10, 0, 0, 1);
    check("m10u_acc",      acc_out,  {24'h00001B, 24'h00000C, 24'h000006, 24'h000003});
    check("m10u_beat_cnt", beat_cnt, 3);
    check("m10u_out_mode", out_mode, 2'b10);
    handshake();

    // Mode 10 signed single beat: every nibble is -1
    send(16'hFFFF, 2'b10, 1, 0, 1);
    check("m10s_acc",      acc_out,  {4{24'hFFFFFF}});
    check("m10s_beat_cnt", beat_cnt, 1);
    handshake();

    // Mode 01 signed: lanes 0x80 -> -128, 0x7F -> 127
    send(16'h7F80, 2'b01, 1, 1, 1);
    check("m01s_acc", acc_out, {24'h0, 24'h0, 24'h00007F, 24'hFFFF80});
    handshake();

    // Backpressure with a pending beat held upstream
    send(16'h0005, 2'b00, 0, 0, 1);
    held     = {24'h0, 24'h0, 24'h0, 24'h000005};
    product  = 16'h0007;
    mode     = 2'b00;
    sx       = 1'b0;
    sy       = 1'b0;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready",  in_ready,  0);
      check("bp_out_valid", out_valid, 1);
      check("bp_acc",       acc_out,   held);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("bp_hs_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_bubble_in_ready", in_ready,  1);
    check("bp_bubble_valid",    out_valid, 0);
    check("bp_bubble_acc",      acc_out,   held);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_next_valid",    out_valid, 1);
    check("bp_next_acc",      acc_out,   {24'h0, 24'h0, 24'h0, 24'h000007});
    check("bp_next_beat_cnt", beat_cnt,  1);
    handshake();

    // Wrap: 257 * 0xFFFF = 0x100FEFF, mod 2^24
    for (int i = 0; i < 257; i++) begin
      send(16'hFFFF, 2'b00, 0, 0, (i == 256));
    end
    check("wrap_acc",      acc_out,  {24'h0, 24'h0, 24'h0, 24'h00FEFF});
    check("wrap_beat_cnt", beat_cnt, 257);
    check("wrap_mode_err", mode_err, 0);
    handshake();

    // Mode mismatch: second beat claims mode 10 but is accumulated as mode 01
    send(16'h0302, 2'b01, 0, 0, 0);
    send(16'h5544, 2'b10, 0, 0, 1);
    check("merr_flag",     mode_err, 1);
    check("merr_out_mode", out_mode, 2'b01);
    check("merr_acc",      acc_out,  {24'h0, 24'h0, 24'h000058, 24'h000046});
    handshake();
    check("merr_hold_flag", mode_err, 1);
    send(16'h0002, 2'b00, 0, 0, 0);
    check("merr_clear", mode_err, 0);
    send(16'h0003, 2'b00, 0, 0, 1);
    check("merr_clear_acc", acc_out, {24'h0, 24'h0, 24'h0, 24'h000005});
    handshake();

    // Reserved mode: extracted as 8x8 and flagged
    send(16'h0102, 2'b11, 0, 0, 1);
    check("rsvd_flag",     mode_err, 1);
    check("rsvd_out_mode", out_mode, 2'b11);
    check("rsvd_acc",      acc_out,  {24'h0, 24'h0, 24'h0, 24'h000102});
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
